// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for a 5-stage pipeline: load-use, redirect,
// multi-cycle EX and data-memory wait resolved under one fixed priority.
module pipe_hazard_ctrl #(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_redirect,
  input  logic              ex_mc_start,
  input  logic              dmem_ready,
  output logic              pc_we,
  output logic              pc_redirect,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_we,
  output logic              idex_flush,
  output logic              exmem_we,
  output logic              exmem_flush,
  output logic              memwb_we,
  output logic              memwb_flush,
  output logic              busy,
  output logic [PERF_W-1:0] stall_count
);

  typedef enum logic {RUN, MC_WAIT} state_e;

  localparam bit          MC_EN   = (MC_LAT > 1);
  localparam int unsigned MC_LOAD = MC_EN ? (MC_LAT - 2) : 0;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERF_W-1:0]   stall_count_q, stall_count_d;
  logic                mc_stall;
  logic                load_use;

  // The whole FSM freezes while memory is not ready, so a multi-cycle op whose
  // final cycle coincides with a MEM wait cannot re-trigger from RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_mc_start && MC_EN && dmem_ready) begin
          mc_stall = 1'b1;
          state_d  = MC_WAIT;
          cnt_d    = CNT_W'(MC_LOAD);
        end
      end
      MC_WAIT: begin
        if (cnt_q != '0) begin
          mc_stall = 1'b1;
          if (dmem_ready) cnt_d = cnt_q - CNT_W'(1);
        end else if (dmem_ready) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  end

  always_comb begin
    pc_we       = 1'b1;
    pc_redirect = 1'b0;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    exmem_flush = 1'b0;
    memwb_we    = 1'b1;
    memwb_flush = 1'b0;
    if (!dmem_ready) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mc_stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_flush = 1'b1;
    end else if (ex_redirect) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (load_use) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_we && (stall_count_q != '1)) stall_count_d = stall_count_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign busy        = (state_q == MC_WAIT);
  assign stall_count = stall_count_q;

endmodule
